// File: rtl/thread_sched.sv
// Hardware-thread lifecycle tracker (FREE/RUN/SLEEP) with round-robin fetch grant.
// WB sleep/wake/kill events update thread state and raise one-cycle flush / PC-load pulses.
module thread_sched #(
  parameter int NUM_THREAD = 4,
  parameter int TID_W      = $clog2(NUM_THREAD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sleep,
  input  logic                  wake,
  input  logic                  kill,
  input  logic [TID_W-1:0]      trd_id_wb,
  input  logic [TID_W-1:0]      wake_tid,
  input  logic [31:0]           wake_pc,
  input  logic                  stall,
  output logic                  fetch_valid,
  output logic [TID_W-1:0]      fetch_tid,
  output logic                  flush_valid,
  output logic [TID_W-1:0]      flush_tid,
  output logic                  pc_load_valid,
  output logic [TID_W-1:0]      pc_load_tid,
  output logic [31:0]           pc_load_pc,
  output logic [NUM_THREAD-1:0] run_mask,
  output logic [NUM_THREAD-1:0] sleep_mask,
  output logic                  halt
);

  typedef enum logic [1:0] {
    T_FREE  = 2'd0,
    T_RUN   = 2'd1,
    T_SLEEP = 2'd2
  } tstate_t;

  tstate_t          st [NUM_THREAD];
  logic [TID_W-1:0] ptr;
  logic [TID_W-1:0] scan_idx;
  logic             do_sleep;
  logic             do_wake;
  logic             do_kill;

  // Simultaneous events are malformed and dropped as a whole.
  assign do_sleep = sleep & ~wake & ~kill;
  assign do_wake  = wake & ~sleep & ~kill;
  assign do_kill  = kill & ~sleep & ~wake;

  always_comb begin
    for (int i = 0; i < NUM_THREAD; i++) begin
      run_mask[i]   = (st[i] == T_RUN);
      sleep_mask[i] = (st[i] == T_SLEEP);
    end
  end

  assign halt = ~|(run_mask | sleep_mask);

  // Scan from the farthest offset down so the nearest RUN thread after ptr wins;
  // offset NUM_THREAD wraps back onto ptr itself.
  always_comb begin
    fetch_valid = 1'b0;
    fetch_tid   = '0;
    scan_idx    = '0;
    for (int k = NUM_THREAD; k >= 1; k--) begin
      scan_idx = ptr + TID_W'(k);
      if (run_mask[scan_idx]) begin
        fetch_valid = 1'b1;
        fetch_tid   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREAD; i++) begin
        st[i] <= (i == 0) ? T_RUN : T_FREE;
      end
      ptr           <= TID_W'(NUM_THREAD - 1);
      flush_valid   <= 1'b0;
      flush_tid     <= '0;
      pc_load_valid <= 1'b0;
      pc_load_tid   <= '0;
      pc_load_pc    <= '0;
    end else begin
      flush_valid   <= 1'b0;
      pc_load_valid <= 1'b0;
      if (do_sleep && st[trd_id_wb] == T_RUN) begin
        st[trd_id_wb] <= T_SLEEP;
        flush_valid   <= 1'b1;
        flush_tid     <= trd_id_wb;
      end
      if (do_kill && st[trd_id_wb] != T_FREE) begin
        st[trd_id_wb] <= T_FREE;
        flush_valid   <= 1'b1;
        flush_tid     <= trd_id_wb;
      end
      if (do_wake) begin
        case (st[wake_tid])
          T_SLEEP: st[wake_tid] <= T_RUN;
          T_FREE: begin
            st[wake_tid]  <= T_RUN;
            pc_load_valid <= 1'b1;
            pc_load_tid   <= wake_tid;
            pc_load_pc    <= wake_pc;
          end
          default: ;
        endcase
      end
      if (fetch_valid && !stall) begin
        ptr <= fetch_tid;
      end
    end
  end

endmodule

// File: tb/tb_thread_sched.sv
// Bench for thread_sched: directed WB event sequences with a per-cycle reference model
// of thread states and round-robin pointer, plus literal expectations along the way.
module tb_thread_sched;
  localparam int N = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sleep = 1'b0, wake = 1'b0, kill = 1'b0, stall = 1'b0;
  logic [TW-1:0] trd_id_wb = '0, wake_tid = '0;
  logic [31:0]   wake_pc = '0;
  logic          fetch_valid, flush_valid, pc_load_valid, halt;
  logic [TW-1:0] fetch_tid, flush_tid, pc_load_tid;
  logic [31:0]   pc_load_pc;
  logic [N-1:0]  run_mask, sleep_mask;

  int tests = 0;
  int fails = 0;

  thread_sched #(.NUM_THREAD(N), .TID_W(TW)) dut (
    .clk(clk), .rst(rst), .sleep(sleep), .wake(wake), .kill(kill),
    .trd_id_wb(trd_id_wb), .wake_tid(wake_tid), .wake_pc(wake_pc), .stall(stall),
    .fetch_valid(fetch_valid), .fetch_tid(fetch_tid),
    .flush_valid(flush_valid), .flush_tid(flush_tid),
    .pc_load_valid(pc_load_valid), .pc_load_tid(pc_load_tid), .pc_load_pc(pc_load_pc),
    .run_mask(run_mask), .sleep_mask(sleep_mask), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: thread status as strings-of-meaning ints (0 idle, 1 running, 2 asleep).
  int          m_st [N];
  int          m_ptr;
  bit          e_flush, e_load;
  int          e_ftid, e_ltid;
  logic [31:0] e_lpc;

  function automatic int m_grant();
    for (int k = 1; k <= N; k++) begin
      if (m_st[(m_ptr + k) % N] == 1) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    int nev;
    if (rst) begin
      for (int i = 0; i < N; i++) m_st[i] <= (i == 0) ? 1 : 0;
      m_ptr   <= N - 1;
      e_flush <= 1'b0;
      e_load  <= 1'b0;
    end else begin
      g   = m_grant();
      nev = int'(sleep) + int'(wake) + int'(kill);
      e_flush <= 1'b0;
      e_load  <= 1'b0;
      if (nev == 1) begin
        if (sleep && m_st[trd_id_wb] == 1) begin
          m_st[trd_id_wb] <= 2;
          e_flush <= 1'b1;
          e_ftid  <= int'(trd_id_wb);
        end
        if (kill && m_st[trd_id_wb] != 0) begin
          m_st[trd_id_wb] <= 0;
          e_flush <= 1'b1;
          e_ftid  <= int'(trd_id_wb);
        end
        if (wake && m_st[wake_tid] == 2) m_st[wake_tid] <= 1;
        if (wake && m_st[wake_tid] == 0) begin
          m_st[wake_tid] <= 1;
          e_load <= 1'b1;
          e_ltid <= int'(wake_tid);
          e_lpc  <= wake_pc;
        end
      end
      if (g >= 0 && !stall) m_ptr <= g;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] rm, sm;
    g = m_grant();
    for (int i = 0; i < N; i++) begin
      rm[i] = (m_st[i] == 1);
      sm[i] = (m_st[i] == 2);
    end
    chk("model_fetch_valid", fetch_valid, (g >= 0) ? 1 : 0);
    chk("model_fetch_tid", fetch_tid, (g >= 0) ? g : 0);
    chk("model_run_mask", run_mask, rm);
    chk("model_sleep_mask", sleep_mask, sm);
    chk("model_halt", halt, (rm == '0 && sm == '0) ? 1 : 0);
    chk("model_flush_valid", flush_valid, e_flush);
    if (e_flush) chk("model_flush_tid", flush_tid, e_ftid);
    chk("model_pc_load_valid", pc_load_valid, e_load);
    if (e_load) begin
      chk("model_pc_load_tid", pc_load_tid, e_ltid);
      chk("model_pc_load_pc", pc_load_pc, e_lpc);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ev(input logic s, input logic w, input logic k, input int tid,
                    input int wt, input logic [31:0] pc);
    sleep = s; wake = w; kill = k;
    trd_id_wb = TW'(tid); wake_tid = TW'(wt); wake_pc = pc;
  endtask

  task automatic idle();
    ev(1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq_a [6] = '{0, 1, 2, 0, 1, 2};
    int seq_b [3] = '{2, 0, 2};
    repeat (2) @(negedge clk);
    chk("rst_flush_tid", flush_tid, 0);
    chk("rst_pc_load_tid", pc_load_tid, 0);
    chk("rst_pc_load_pc", pc_load_pc, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      chk("solo_fetch_tid", fetch_tid, 0);
      chk("solo_run_mask", run_mask, 4'b0001);
      chk("solo_halt", halt, 0);
      step();
    end

    ev(0, 1, 0, 0, 1, 32'h100); step(); idle();
    chk("wake1_pl_valid", pc_load_valid, 1);
    chk("wake1_pl_tid", pc_load_tid, 1);
    chk("wake1_pl_pc", pc_load_pc, 32'h100);
    chk("wake1_run", run_mask, 4'b0011);
    ev(0, 1, 0, 0, 2, 32'h200); step(); idle();
    chk("wake2_pl_valid", pc_load_valid, 1);
    chk("wake2_pl_tid", pc_load_tid, 2);
    chk("wake2_pl_pc", pc_load_pc, 32'h200);
    chk("wake2_run", run_mask, 4'b0111);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr3_fetch", fetch_tid, seq_a[i]);
    end

    ev(1, 0, 0, 1, 0, 32'h0); step(); idle();
    chk("sleep1_flush_valid", flush_valid, 1);
    chk("sleep1_flush_tid", flush_tid, 1);
    chk("sleep1_sleep_mask", sleep_mask, 4'b0010);
    chk("sleep1_fetch", fetch_tid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("alt_fetch", fetch_tid, seq_b[i]);
    end
    ev(0, 1, 0, 0, 1, 32'h999); step(); idle();
    chk("rewake_no_pl", pc_load_valid, 0);
    chk("rewake_run", run_mask, 4'b0111);
    chk("rewake_fetch", fetch_tid, 0);
    step(); chk("rejoin_fetch1", fetch_tid, 1);
    step(); chk("rejoin_fetch2", fetch_tid, 2);

    ev(0, 0, 1, 2, 0, 32'h0); step(); idle();
    chk("kill2_flush_tid", flush_tid, 2);
    chk("kill2_run", run_mask, 4'b0011);
    stall = 1'b1;
    chk("stall_fetch", fetch_tid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_fetch", fetch_tid, 0);
    end
    stall = 1'b0;
    step(); chk("unstall_fetch1", fetch_tid, 1);
    step(); chk("unstall_fetch0", fetch_tid, 0);

    ev(0, 0, 1, 1, 0, 32'h0); step(); idle();
    chk("kill1_flush_tid", flush_tid, 1);
    chk("kill1_run", run_mask, 4'b0001);
    ev(0, 0, 1, 0, 0, 32'h0); step(); idle();
    chk("kill0_flush_valid", flush_valid, 1);
    chk("kill0_flush_tid", flush_tid, 0);
    chk("kill0_fetch_valid", fetch_valid, 0);
    chk("kill0_halt", halt, 1);
    step();
    chk("halted_flush_off", flush_valid, 0);
    chk("halted_halt", halt, 1);
    ev(0, 1, 0, 0, 3, 32'h300); step(); idle();
    chk("wake3_pl_tid", pc_load_tid, 3);
    chk("wake3_pl_pc", pc_load_pc, 32'h300);
    chk("wake3_run", run_mask, 4'b1000);
    #2 rst = 1'b1;
    #1;
    chk("arst_pl_valid", pc_load_valid, 0);
    chk("arst_run", run_mask, 4'b0001);
    chk("arst_fetch_valid", fetch_valid, 1);
    chk("arst_fetch_tid", fetch_tid, 0);
    chk("arst_halt", halt, 0);
    @(negedge clk);
    rst = 1'b0;

    ev(0, 1, 0, 0, 1, 32'h40); step(); idle();
    ev(1, 0, 0, 1, 0, 32'h0); step(); idle();
    chk("edge_setup_sleep", sleep_mask, 4'b0010);
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: ev(0, 1, 0, 0, 0, 32'h55);
        1: ev(1, 0, 0, 1, 0, 32'h0);
        2: ev(0, 0, 1, 2, 0, 32'h0);
        default: ev(1, 0, 1, 0, 0, 32'h0);
      endcase
      step(); idle();
      chk("edge_flush", flush_valid, 0);
      chk("edge_pl", pc_load_valid, 0);
      chk("edge_run", run_mask, 4'b0001);
      chk("edge_sleep", sleep_mask, 4'b0010);
    end
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
